mux2_stream_arbiter: RTL and testbench
======================================

// Module: mux2_stream_arbiter
// PURPOSE
//  Two-source, packet-aware round-robin arbiter. It generates the select for a 2:1 data mux and
//  registers the chosen beat. It sits directly upstream of the mux: the mux select input 's' is
//  driven from 'sel'.
//  Sources use valid/ready handshakes; a packet ends on the beat with 'last' set. Once a source is
//  granted, it keeps the grant until its packet completes.
// PARAMETERS
//  DATA_W    8   width of data on each source and on the output
//  MAX_PKT   16  beats after which a lock is force-released (counter saturation guard); must be >= 2
// PORTS
//  clk        in   1       rising-edge clock
//  rst_n      in   1       asynchronous active-low reset
//  a0_valid   in   1       source 0 beat valid
//  a0_data    in   DATA_W  source 0 data
//  a0_last    in   1       source 0 final beat of packet
//  a0_ready   out  1       source 0 beat accepted when a0_valid&a0_ready
//  a1_valid   in   1       source 1 beat valid
//  a1_data    in   DATA_W  source 1 data
//  a1_last    in   1       source 1 final beat of packet
//  a1_ready   out  1       source 1 beat accepted when a1_valid&a1_ready
//  sel        out  1       current grant (0=A0, 1=A1); drives mux select
//  out_valid  out  1       registered beat valid
//  out_data   out  DATA_W  registered beat data
//  out_last   out  1       registered last flag
//  out_ready  in   1       downstream accepts beat when out_valid&out_ready
// BEHAVIOUR
//  Reset (async, rst_n=0):
//   - state=IDLE, sel=0, prio=0, out_valid=0, out_data=0, out_last=0, beat_cnt=0
//   - a0_ready=a1_ready=0 while rst_n=0
//   - an in-flight packet is dropped; no partial-beat recovery
//  Output register:
//   - load_en = !out_valid | out_ready
//   - granted beat loads on the clk edge where valid&ready; 1-cycle latency
//   - out_valid stays set with data stable until out_ready is sampled high
//   - with load_en=1 every cycle, full throughput of 1 beat/cycle
//  FSM states:
//   - IDLE: sel = prio, a0_ready=a1_ready=0
//     - only one source valid: grant it (-> LOCK0/LOCK1)
//     - both valid: grant source 'prio'
//     - transition is taken on the edge; first beat is accepted no earlier than the next cycle
//       (1 idle cycle of arbitration)
//   - LOCK0: sel=0, a0_ready=load_en, a1_ready=0
//     - on an accepted beat with a0_last=1: prio<=1, -> IDLE
//   - LOCK1: mirror of LOCK0 with roles swapped; on accepted a1_last=1: prio<=0, -> IDLE
//  Lock counter:
//   - beat_cnt counts accepted beats in the current lock; cleared on entering IDLE
//   - when beat_cnt reaches MAX_PKT-1 and a beat is accepted: treat that beat as last
//     - out_last=1, priority flips, -> IDLE
//  Boundary conditions:
//   - valid deasserting mid-packet: the lock holds, no grant change; ready still follows load_en
//   - single-beat packet (last on first beat): lock lasts exactly 1 accepted beat
//   - out_ready low: ready to the locked source drops in the same cycle (combinational from
//     out_valid/out_ready); no beat is lost or duplicated
//   - a source never sees ready while it is not granted; the unselected source's data is ignored
//   - sel changes only in IDLE or on the edge leaving a lock, never mid-packet
// TESTING
//  1 Reset:
//    - rst_n=0 mid-packet -> out_valid=0, sel=0, both readies 0 immediately (async)
//    - after release, state IDLE
//  2 Single source:
//    - A0 sends 3 beats 0x11,0x22,0x33(last), out_ready=1
//    - -> out_data 0x11,0x22,0x33 on consecutive cycles, one cycle after each acceptance
//    - -> out_last on 0x33; sel=0 throughout
//  3 Contention:
//    - both valid from reset, 2-beat packets each
//    - -> A0 packet first (prio=0), then A1 packet
//    - -> then A0 again; sel toggles only between packets
//  4 Backpressure:
//    - out_ready=0 for 4 cycles mid-packet
//    - -> out_data held stable, a*_ready=0
//    - -> no beat lost or duplicated after resume (scoreboard compare)
//  5 Gap in lock:
//    - A0 drops valid for 2 cycles mid-packet while A1 is valid
//    - -> sel stays 0, a1_ready=0 until A0's last beat
//  6 Forced release:
//    - MAX_PKT=16, A0 streams 20 beats with no last
//    - -> beat 16 emitted with out_last=1
//    - -> grant passes to waiting A1

Source files
------------

// File: rtl/mux2_stream_arbiter_if.sv
// Handshake bundle for the two-source packet arbiter: two valid/ready sources,
// the mux select and the registered output beat.
interface mux2_stream_arbiter_if #(
  parameter int unsigned DATA_W = 8
);
  logic              a0_valid;
  logic [DATA_W-1:0] a0_data;
  logic              a0_last;
  logic              a0_ready;
  logic              a1_valid;
  logic [DATA_W-1:0] a1_data;
  logic              a1_last;
  logic              a1_ready;
  logic              sel;
  logic              out_valid;
  logic [DATA_W-1:0] out_data;
  logic              out_last;
  logic              out_ready;

  // Arbiter side.
  modport slave (
    input  a0_valid, a0_data, a0_last,
    input  a1_valid, a1_data, a1_last,
    input  out_ready,
    output a0_ready, a1_ready, sel,
    output out_valid, out_data, out_last
  );

  // Source/sink side.
  modport master (
    output a0_valid, a0_data, a0_last,
    output a1_valid, a1_data, a1_last,
    output out_ready,
    input  a0_ready, a1_ready, sel,
    input  out_valid, out_data, out_last
  );
endinterface

// File: rtl/mux2_stream_arbiter.sv
// Packet-aware round-robin arbiter for two valid/ready sources. Drives the 2:1 mux select
// and registers the granted beat; a grant is held until the packet's last beat.
module mux2_stream_arbiter #(
  parameter int unsigned DATA_W  = 8,
  parameter int unsigned MAX_PKT = 16
) (
  input logic                 clk,
  input logic                 rst_n,
  mux2_stream_arbiter_if.slave bus
);

  localparam int unsigned CntW = $clog2(MAX_PKT);

  typedef enum logic [1:0] {StIdle, StLock0, StLock1} state_e;

  state_e            state_q, state_d;
  logic              prio_q, prio_d;
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic              out_valid_q, out_valid_d;
  logic [DATA_W-1:0] out_data_q, out_data_d;
  logic              out_last_q, out_last_d;

  logic load_en;
  logic sel_c;
  logic a0_rdy, a1_rdy;
  logic accept;
  logic beat_last;

  assign load_en = !out_valid_q || bus.out_ready;

  always_comb begin
    state_d     = state_q;
    prio_d      = prio_q;
    cnt_d       = cnt_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_last_d  = out_last_q;
    sel_c       = prio_q;
    a0_rdy      = 1'b0;
    a1_rdy      = 1'b0;

    unique case (state_q)
      StIdle: begin
        // One arbitration cycle: the grant is taken on the edge, beats flow from the next cycle.
        sel_c = prio_q;
        cnt_d = '0;
        if (bus.a0_valid && bus.a1_valid) begin
          state_d = prio_q ? StLock1 : StLock0;
        end else if (bus.a0_valid) begin
          state_d = StLock0;
        end else if (bus.a1_valid) begin
          state_d = StLock1;
        end
      end
      StLock0: begin
        sel_c  = 1'b0;
        a0_rdy = load_en;
      end
      StLock1: begin
        sel_c  = 1'b1;
        a1_rdy = load_en;
      end
      default: state_d = StIdle;
    endcase

    accept    = (a0_rdy && bus.a0_valid) || (a1_rdy && bus.a1_valid);
    // Saturated lock counter forces a release so one source cannot starve the other.
    beat_last = (sel_c ? bus.a1_last : bus.a0_last) || (cnt_q == CntW'(MAX_PKT - 1));

    if (accept) begin
      out_valid_d = 1'b1;
      out_data_d  = sel_c ? bus.a1_data : bus.a0_data;
      out_last_d  = beat_last;
      if (beat_last) begin
        state_d = StIdle;
        prio_d  = ~sel_c;
        cnt_d   = '0;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end else if (bus.out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      prio_q      <= 1'b0;
      cnt_q       <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_last_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      prio_q      <= prio_d;
      cnt_q       <= cnt_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_last_q  <= out_last_d;
    end
  end

  assign bus.sel       = sel_c;
  assign bus.a0_ready  = a0_rdy;
  assign bus.a1_ready  = a1_rdy;
  assign bus.out_valid = out_valid_q;
  assign bus.out_data  = out_data_q;
  assign bus.out_last  = out_last_q;

endmodule

// File: tb/tb_mux2_stream_arbiter.sv
// Bench for mux2_stream_arbiter: directed scenarios plus randomized traffic, checked each cycle
// against a packet-level reference model of the arbitration rules.
module tb_mux2_stream_arbiter;

  localparam int unsigned DW     = 8;
  localparam int unsigned MaxPkt = 16;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  mux2_stream_arbiter_if #(.DATA_W(DW)) bus ();

  mux2_stream_arbiter #(
    .DATA_W (DW),
    .MAX_PKT(MaxPkt)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  int tests = 0;
  int fails = 0;

  // Pending beats per source as {last, data}; got collects beats seen leaving the output.
  logic [DW:0] q0[$];
  logic [DW:0] q1[$];
  logic [DW:0] got[$];
  logic [DW:0] expq[$];
  logic        gap0 = 1'b0;
  logic        gap1 = 1'b0;

  // Reference model: who owns the grant (-1 = nobody), whose turn it is on a tie,
  // beats taken in the current packet, and the one-entry output slot.
  int          owner;
  logic        m_prio;
  int          m_cnt;
  logic        m_ov;
  logic        m_ol;
  logic [DW-1:0] m_od;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic drive();
    logic [DW:0] h0, h1;
    h0 = (q0.size() > 0) ? q0[0] : '0;
    h1 = (q1.size() > 0) ? q1[0] : '0;
    bus.a0_valid = (q0.size() > 0) && !gap0;
    bus.a0_data  = h0[DW-1:0];
    bus.a0_last  = h0[DW];
    bus.a1_valid = (q1.size() > 0) && !gap1;
    bus.a1_data  = h1[DW-1:0];
    bus.a1_last  = h1[DW];
  endtask

  task automatic cyc();
    logic ld, sl, r0, r1, acc, lst;
    logic [DW:0] h;
    drive();
    @(negedge clk);
    ld = !m_ov || bus.out_ready;
    sl = (owner < 0) ? m_prio : (owner == 1);
    r0 = (owner == 0) && ld;
    r1 = (owner == 1) && ld;
    chk("sel", bus.sel, sl);
    chk("a0_ready", bus.a0_ready, r0);
    chk("a1_ready", bus.a1_ready, r1);
    chk("out_valid", bus.out_valid, m_ov);
    chk("out_last", bus.out_last, m_ol);
    chk("out_data", bus.out_data, m_od);
    if (bus.out_valid && bus.out_ready) got.push_back({bus.out_last, bus.out_data});
    @(posedge clk);
    acc = (r0 && bus.a0_valid) || (r1 && bus.a1_valid);
    if (acc) begin
      h    = (owner == 0) ? q0.pop_front() : q1.pop_front();
      lst  = h[DW] || (m_cnt == MaxPkt - 1);
      m_ov = 1'b1;
      m_od = h[DW-1:0];
      m_ol = lst;
      if (lst) begin
        m_prio = (owner == 0);
        owner  = -1;
        m_cnt  = 0;
      end else begin
        m_cnt++;
      end
    end else begin
      if (bus.out_ready) m_ov = 1'b0;
      if (owner < 0) begin
        if (bus.a0_valid && bus.a1_valid) owner = m_prio ? 1 : 0;
        else if (bus.a0_valid)            owner = 0;
        else if (bus.a1_valid)            owner = 1;
      end
    end
    #1;
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) cyc();
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    q0.delete();
    q1.delete();
    gap0 = 1'b0;
    gap1 = 1'b0;
    bus.out_ready = 1'b1;
    drive();
    owner  = -1;
    m_prio = 1'b0;
    m_cnt  = 0;
    m_ov   = 1'b0;
    m_ol   = 1'b0;
    m_od   = '0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    got.delete();
    expq.delete();
  endtask

  task automatic check_got(input string tag);
    chk($sformatf("%s_count", tag), got.size(), expq.size());
    for (int i = 0; i < expq.size() && i < got.size(); i++) begin
      chk($sformatf("%s_beat%0d", tag, i), got[i], expq[i]);
    end
  endtask

  task automatic push_pkt(input int src, input int len);
    logic [DW:0] b;
    for (int i = 0; i < len; i++) begin
      b[DW-1:0] = DW'($urandom);
      b[DW]     = (i == len - 1);
      if (src == 0) q0.push_back(b);
      else          q1.push_back(b);
    end
  endtask

  initial begin
    // Asynchronous reset in the middle of a packet.
    do_reset();
    for (int i = 0; i < 5; i++) q0.push_back(9'h0A0 + 9'(i));
    run(3);
    #2 rst_n = 1'b0;
    #1;
    chk("rst_out_valid", bus.out_valid, 1'b0);
    chk("rst_sel", bus.sel, 1'b0);
    chk("rst_a0_ready", bus.a0_ready, 1'b0);
    chk("rst_a1_ready", bus.a1_ready, 1'b0);
    chk("rst_out_data", bus.out_data, 8'h00);
    do_reset();
    run(2);

    // Single source, three-beat packet.
    q0.push_back(9'h011);
    q0.push_back(9'h022);
    q0.push_back(9'h133);
    run(8);
    expq.push_back(9'h011);
    expq.push_back(9'h022);
    expq.push_back(9'h133);
    check_got("single");

    // Contention from reset: A0 first, then A1, then A0 again.
    do_reset();
    q0.push_back(9'h0A1);
    q0.push_back(9'h1A2);
    q0.push_back(9'h0A3);
    q0.push_back(9'h1A4);
    q1.push_back(9'h0B1);
    q1.push_back(9'h1B2);
    run(16);
    expq.push_back(9'h0A1);
    expq.push_back(9'h1A2);
    expq.push_back(9'h0B1);
    expq.push_back(9'h1B2);
    expq.push_back(9'h0A3);
    expq.push_back(9'h1A4);
    check_got("contend");

    // Backpressure for four cycles mid-packet.
    do_reset();
    for (int i = 1; i <= 4; i++) q0.push_back(9'h040 + 9'(i));
    q0.push_back(9'h145);
    run(3);
    bus.out_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      cyc();
      chk("bp_hold_data", bus.out_data, 8'h42);
      chk("bp_a0_ready", bus.a0_ready, 1'b0);
    end
    bus.out_ready = 1'b1;
    run(10);
    for (int i = 1; i <= 4; i++) expq.push_back(9'h040 + 9'(i));
    expq.push_back(9'h145);
    check_got("backpressure");

    // A0 gaps mid-packet while A1 waits.
    do_reset();
    q0.push_back(9'h051);
    q0.push_back(9'h052);
    q0.push_back(9'h053);
    q0.push_back(9'h154);
    q1.push_back(9'h1B5);
    run(3);
    gap0 = 1'b1;
    for (int i = 0; i < 2; i++) begin
      cyc();
      chk("gap_sel", bus.sel, 1'b0);
      chk("gap_a1_ready", bus.a1_ready, 1'b0);
    end
    gap0 = 1'b0;
    run(10);
    expq.push_back(9'h051);
    expq.push_back(9'h052);
    expq.push_back(9'h053);
    expq.push_back(9'h154);
    expq.push_back(9'h1B5);
    check_got("gap");

    // Forced release after MaxPkt beats without last.
    do_reset();
    for (int i = 0; i < 20; i++) q0.push_back(9'h060 + 9'(i));
    q1.push_back(9'h1C0);
    run(32);
    for (int i = 0; i < 15; i++) expq.push_back(9'h060 + 9'(i));
    expq.push_back(9'h16F);
    expq.push_back(9'h1C0);
    for (int i = 16; i < 20; i++) expq.push_back(9'h060 + 9'(i));
    check_got("force");

    // Randomized traffic, including packets longer than MaxPkt.
    do_reset();
    for (int i = 0; i < 1500; i++) begin
      if (q0.size() < 3 && $urandom_range(0, 3) == 0) push_pkt(0, int'($urandom_range(1, 20)));
      if (q1.size() < 3 && $urandom_range(0, 3) == 0) push_pkt(1, int'($urandom_range(1, 20)));
      gap0          = ($urandom_range(0, 4) == 0);
      gap1          = ($urandom_range(0, 4) == 0);
      bus.out_ready = ($urandom_range(0, 3) != 0);
      cyc();
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
